match_controller: RTL and testbench

- Parametrised successor to the fixed two-player score/game-state logic; runs a match for NUM_PLAYERS players.
- Provides serve and post-point countdowns timed by the 1 ms tick, a pause mode with exact resume, winner detection and serve rotation.
- Sits between ball/collision logic (point reports) and render/seven-segment logic (state, scores). Gates ball motion via ball_enable.

---
 rtl/pong_pkg.sv | 19 +
 rtl/edge_pulse.sv | 22 ++
 rtl/match_controller.sv | 225 ++++++++++++++++++++++
 tb/tb_match_controller.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared definitions for the pong match, render and seven-segment blocks.
// The game-state encoding is visible on the match_controller output, so the values are fixed.
package pong_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StServe  = 3'd1,
    StPlay   = 3'd2,
    StPoint  = 3'd3,
    StPaused = 3'd4,
    StOver   = 3'd5
  } game_state_e;

  // Width of a player index; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/edge_pulse.sv
// Rising-edge detector for a synchronous button level.
// The previous value resets to 1, so a button held through reset produces no edge.
module edge_pulse (
  input  logic clk_i,
  input  logic reset_i,
  input  logic level_i,
  output logic pulse_o
);

  logic prev_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= level_i;
    end
  end

  assign pulse_o = level_i & ~prev_q;

endmodule

// File: rtl/match_controller.sv
// Match sequencing for NUM_PLAYERS players: serve/point countdowns, pause with exact resume,
// scoring, winner detection and serve rotation. Every output is registered.
module match_controller
  import pong_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned SCORE_W     = 4,
  parameter int unsigned WIN_SCORE   = 9,
  parameter int unsigned SERVE_MS    = 1000,
  parameter int unsigned POINT_MS    = 500,
  localparam int unsigned IDX_W      = idx_width(NUM_PLAYERS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           tick_1ms,
  input  logic                           start,
  input  logic                           pause,
  input  logic                           point_valid,
  input  logic [IDX_W-1:0]               point_player,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
  output logic [2:0]                     game_state,
  output logic                           ball_enable,
  output logic [IDX_W-1:0]               serve_dir,
  output logic                           point_ack,
  output logic [IDX_W-1:0]               winner,
  output logic                           winner_valid
);

  localparam int unsigned CntMax = (SERVE_MS > POINT_MS) ? SERVE_MS : POINT_MS;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] ServeLast = CntW'(SERVE_MS - 1);
  localparam logic [CntW-1:0] PointLast = CntW'(POINT_MS - 1);

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] p);
    int unsigned n;
    n = (32'(p) + 1) % NUM_PLAYERS;
    return IDX_W'(n);
  endfunction

  game_state_e state_q, state_d, saved_q, saved_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [SCORE_W-1:0] score_q [NUM_PLAYERS];
  logic [SCORE_W-1:0] score_d [NUM_PLAYERS];
  logic [IDX_W-1:0]   serve_dir_q, serve_dir_d;
  logic [IDX_W-1:0]   winner_q, winner_d;
  logic               winner_valid_q, winner_valid_d;
  logic               point_ack_q, point_ack_d;
  logic               ball_enable_q, ball_enable_d;

  logic start_edge, pause_edge;
  logic pt_ok, pt_win;

  edge_pulse u_start_edge (
    .clk_i   (clk),
    .reset_i (reset),
    .level_i (start),
    .pulse_o (start_edge)
  );

  edge_pulse u_pause_edge (
    .clk_i   (clk),
    .reset_i (reset),
    .level_i (pause),
    .pulse_o (pause_edge)
  );

  // Out-of-range player indices are never accepted.
  always_comb begin
    pt_ok  = point_valid && (state_q == StPlay) && (32'(point_player) < NUM_PLAYERS);
    pt_win = 1'b0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (pt_ok && (point_player == IDX_W'(i)) && ((32'(score_q[i]) + 1) == WIN_SCORE)) begin
        pt_win = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      saved_q        <= StServe;
      cnt_q          <= '0;
      serve_dir_q    <= '0;
      winner_q       <= '0;
      winner_valid_q <= 1'b0;
      point_ack_q    <= 1'b0;
      ball_enable_q  <= 1'b0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        score_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      saved_q        <= saved_d;
      cnt_q          <= cnt_d;
      serve_dir_q    <= serve_dir_d;
      winner_q       <= winner_d;
      winner_valid_q <= winner_valid_d;
      point_ack_q    <= point_ack_d;
      ball_enable_q  <= ball_enable_d;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        score_q[i] <= score_d[i];
      end
    end
  end

  // Next state and countdown; a pause edge beats a tick in the same cycle.
  always_comb begin
    state_d = state_q;
    saved_d = saved_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start_edge) begin
          state_d = StServe;
          cnt_d   = '0;
        end
      end
      StServe: begin
        if (pause_edge) begin
          state_d = StPaused;
          saved_d = StServe;
        end else if (tick_1ms) begin
          if (cnt_q == ServeLast) begin
            state_d = StPlay;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StPlay: begin
        if (pt_ok) begin
          state_d = pt_win ? StOver : StPoint;
          cnt_d   = '0;
        end else if (pause_edge) begin
          state_d = StPaused;
          saved_d = StPlay;
        end
      end
      StPoint: begin
        if (pause_edge) begin
          state_d = StPaused;
          saved_d = StPoint;
        end else if (tick_1ms) begin
          if (cnt_q == PointLast) begin
            state_d = StServe;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StPaused: begin
        if (pause_edge) begin
          state_d = saved_q;
        end
      end
      StOver: begin
        if (start_edge) begin
          state_d = StServe;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Registered outputs: scores, serve rotation, winner and acknowledge.
  always_comb begin
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      score_d[i] = score_q[i];
    end
    serve_dir_d    = serve_dir_q;
    winner_d       = winner_q;
    winner_valid_d = winner_valid_q;
    point_ack_d    = 1'b0;
    ball_enable_d  = (state_d == StPlay);

    if ((state_q == StIdle) && start_edge) begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        score_d[i] = '0;
      end
      serve_dir_d = '0;
    end

    if (pt_ok) begin
      point_ack_d = 1'b1;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        if (point_player == IDX_W'(i)) begin
          score_d[i] = score_q[i] + 1'b1;
        end
      end
      if (pt_win) begin
        winner_d       = point_player;
        winner_valid_d = 1'b1;
      end else begin
        serve_dir_d = next_idx(point_player);
      end
    end

    // The player after the winner receives the first serve of the rematch.
    if ((state_q == StOver) && start_edge) begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        score_d[i] = '0;
      end
      winner_valid_d = 1'b0;
      serve_dir_d    = next_idx(winner_q);
    end
  end

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_scores
    assign scores[g*SCORE_W +: SCORE_W] = score_q[g];
  end

  assign game_state   = state_q;
  assign ball_enable  = ball_enable_q;
  assign serve_dir    = serve_dir_q;
  assign point_ack    = point_ack_q;
  assign winner       = winner_q;
  assign winner_valid = winner_valid_q;

endmodule

// File: tb/tb_match_controller.sv
// Directed, table-driven bench for match_controller with 3 players, win at 3,
// a 3-tick serve and a 2-tick post-point countdown.
module tb_match_controller;

  localparam int unsigned NP = 3;
  localparam int unsigned SW = 4;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SERVE  = 3'd1;
  localparam logic [2:0] PLAY   = 3'd2;
  localparam logic [2:0] POINT  = 3'd3;
  localparam logic [2:0] PAUSED = 3'd4;
  localparam logic [2:0] OVER   = 3'd5;

  logic              clk = 1'b0;
  logic              reset, tick_1ms, start, pause, point_valid;
  logic [1:0]        point_player;
  logic [NP*SW-1:0]  scores;
  logic [2:0]        game_state;
  logic              ball_enable, point_ack, winner_valid;
  logic [1:0]        serve_dir, winner;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       name;
    logic        start;
    logic        pause;
    logic        tick;
    logic        pv;
    logic [1:0]  pp;
    logic [2:0]  st;
    logic        ball;
    logic        ack;
    logic [11:0] sc;
    logic [1:0]  dir;
    logic        wv;
    logic [1:0]  win;
  } vec_t;

  vec_t vecs[$];

  match_controller #(
    .NUM_PLAYERS (NP),
    .SCORE_W     (SW),
    .WIN_SCORE   (3),
    .SERVE_MS    (3),
    .POINT_MS    (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tick_1ms     (tick_1ms),
    .start        (start),
    .pause        (pause),
    .point_valid  (point_valid),
    .point_player (point_player),
    .scores       (scores),
    .game_state   (game_state),
    .ball_enable  (ball_enable),
    .serve_dir    (serve_dir),
    .point_ack    (point_ack),
    .winner       (winner),
    .winner_valid (winner_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic r(input string name, input logic st_in, input logic pa, input logic tk,
                   input logic pv, input logic [1:0] pp, input logic [2:0] st,
                   input logic ball, input logic ack, input logic [11:0] sc,
                   input logic [1:0] dir, input logic wv, input logic [1:0] win);
    vec_t v;
    v.name = name; v.start = st_in; v.pause = pa; v.tick = tk; v.pv = pv; v.pp = pp;
    v.st = st; v.ball = ball; v.ack = ack; v.sc = sc; v.dir = dir; v.wv = wv; v.win = win;
    vecs.push_back(v);
  endtask

  // POINT -> SERVE after 2 ticks, then SERVE -> PLAY after 3 ticks.
  task automatic pt_to_play(input logic [11:0] sc, input logic [1:0] dir);
    r("pt_tick1", 1, 1, 1, 0, 0, POINT, 0, 0, sc, dir, 0, 0);
    r("pt_tick2", 1, 1, 1, 0, 0, SERVE, 0, 0, sc, dir, 0, 0);
    r("sv_tick1", 1, 1, 1, 0, 0, SERVE, 0, 0, sc, dir, 0, 0);
    r("sv_tick2", 1, 1, 1, 0, 0, SERVE, 0, 0, sc, dir, 0, 0);
    r("sv_tick3", 1, 1, 1, 0, 0, PLAY,  1, 0, sc, dir, 0, 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"},  32'(game_state),   32'(IDLE));
    check({tag, "_scores"}, 32'(scores),       32'h0);
    check({tag, "_ball"},   32'(ball_enable),  32'h0);
    check({tag, "_dir"},    32'(serve_dir),    32'h0);
    check({tag, "_ack"},    32'(point_ack),    32'h0);
    check({tag, "_win"},    32'(winner),       32'h0);
    check({tag, "_wv"},     32'(winner_valid), 32'h0);
  endtask

  initial begin
    reset = 1'b1; tick_1ms = 1'b0; start = 1'b1; pause = 1'b0;
    point_valid = 1'b0; point_player = '0;

    r("hold_start",    1, 0, 0, 0, 0, IDLE,   0, 0, 12'h000, 0, 0, 0);
    r("rel_start",     0, 0, 0, 0, 0, IDLE,   0, 0, 12'h000, 0, 0, 0);
    r("press_start",   1, 0, 0, 0, 0, SERVE,  0, 0, 12'h000, 0, 0, 0);
    r("serve_t1",      1, 0, 1, 0, 0, SERVE,  0, 0, 12'h000, 0, 0, 0);
    r("serve_t2",      1, 0, 1, 0, 0, SERVE,  0, 0, 12'h000, 0, 0, 0);
    r("serve_gap",     1, 0, 0, 0, 0, SERVE,  0, 0, 12'h000, 0, 0, 0);
    r("serve_t3",      1, 0, 1, 0, 0, PLAY,   1, 0, 12'h000, 0, 0, 0);
    r("p1_scores",     1, 0, 0, 1, 1, POINT,  0, 1, 12'h010, 2, 0, 0);
    r("ack_drops",     1, 0, 0, 0, 0, POINT,  0, 0, 12'h010, 2, 0, 0);
    r("point_t1",      1, 0, 1, 0, 0, POINT,  0, 0, 12'h010, 2, 0, 0);
    r("point_t2",      1, 0, 1, 0, 0, SERVE,  0, 0, 12'h010, 2, 0, 0);
    r("serve2_t1",     1, 0, 1, 0, 0, SERVE,  0, 0, 12'h010, 2, 0, 0);
    r("pause_in",      1, 1, 0, 0, 0, PAUSED, 0, 0, 12'h010, 2, 0, 0);
    for (int i = 0; i < 5; i++) begin
      r("paused_tick", 1, 1, 1, 0, 0, PAUSED, 0, 0, 12'h010, 2, 0, 0);
    end
    r("pause_rel",     1, 0, 0, 0, 0, PAUSED, 0, 0, 12'h010, 2, 0, 0);
    r("resume",        1, 1, 0, 0, 0, SERVE,  0, 0, 12'h010, 2, 0, 0);
    r("resume_t2",     1, 1, 1, 0, 0, SERVE,  0, 0, 12'h010, 2, 0, 0);
    r("resume_t3",     1, 1, 1, 0, 0, PLAY,   1, 0, 12'h010, 2, 0, 0);
    r("bad_player",    1, 1, 0, 1, 3, PLAY,   1, 0, 12'h010, 2, 0, 0);
    r("p2_pt1",        1, 1, 0, 1, 2, POINT,  0, 1, 12'h110, 0, 0, 0);
    pt_to_play(12'h110, 0);
    r("p2_pt2",        1, 1, 0, 1, 2, POINT,  0, 1, 12'h210, 0, 0, 0);
    pt_to_play(12'h210, 0);
    r("pause_low",     1, 0, 0, 0, 0, PLAY,   1, 0, 12'h210, 0, 0, 0);
    r("pt_and_pause",  1, 1, 0, 1, 0, POINT,  0, 1, 12'h211, 1, 0, 0);
    r("pause_dropped", 1, 1, 0, 0, 0, POINT,  0, 0, 12'h211, 1, 0, 0);
    pt_to_play(12'h211, 1);
    r("p2_wins",       1, 1, 0, 1, 2, OVER,   0, 1, 12'h311, 1, 1, 2);
    r("over_pt_ign",   1, 1, 0, 1, 1, OVER,   0, 0, 12'h311, 1, 1, 2);
    r("over_rel",      0, 0, 0, 0, 0, OVER,   0, 0, 12'h311, 1, 1, 2);
    r("over_pause",    0, 1, 1, 0, 0, OVER,   0, 0, 12'h311, 1, 1, 2);
    r("restart",       1, 1, 0, 0, 0, SERVE,  0, 0, 12'h000, 0, 0, 0);
    r("pause_rel2",    1, 0, 0, 0, 0, SERVE,  0, 0, 12'h000, 0, 0, 0);
    r("pause_serve",   1, 1, 1, 0, 0, PAUSED, 0, 0, 12'h000, 0, 0, 0);

    // Reset held with start high.
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[k]) begin
      start = vecs[k].start; pause = vecs[k].pause; tick_1ms = vecs[k].tick;
      point_valid = vecs[k].pv; point_player = vecs[k].pp;
      @(posedge clk);
      #1;
      check({vecs[k].name, "_state"},  32'(game_state),  32'(vecs[k].st));
      check({vecs[k].name, "_ball"},   32'(ball_enable), 32'(vecs[k].ball));
      check({vecs[k].name, "_ack"},    32'(point_ack),   32'(vecs[k].ack));
      check({vecs[k].name, "_scores"}, 32'(scores),      32'(vecs[k].sc));
      check({vecs[k].name, "_dir"},    32'(serve_dir),   32'(vecs[k].dir));
      check({vecs[k].name, "_wv"},     32'(winner_valid), 32'(vecs[k].wv));
      if (vecs[k].wv) check({vecs[k].name, "_winner"}, 32'(winner), 32'(vecs[k].win));
      @(negedge clk);
    end

    // Reset while PAUSED, with pause and start still held high.
    tick_1ms = 1'b0; point_valid = 1'b0; reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_values("rst_paused");
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("held_after_reset_state", 32'(game_state), 32'(IDLE));

    // A tick while IDLE must not start anything.
    @(negedge clk);
    tick_1ms = 1'b1;
    @(posedge clk);
    #1;
    check("idle_tick_state", 32'(game_state), 32'(IDLE));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
